// File: rtl/mtsp_mem_pkg.sv
// Shared types and constants for the MTSP memory responder.
// Beat stride, default widths and the controller state encoding.
package mtsp_mem_pkg;

    localparam int ADDR_W_D   = 32;
    localparam int DATA_W_D   = 128;
    localparam int TID_W_D    = 3;
    localparam int LEN_W_D    = 8;
    localparam int RQ_DEPTH_D = 4;

    // One beat is a DWORDx4, so consecutive beats are 16 bytes apart
    localparam int BEAT_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WR_DONE  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_DRAIN = 3'd4
    } mem_state_e;

endpackage

// File: rtl/mtsp_mem_rqueue.sv
// Read-return queue: synchronous FIFO with occupancy count.
// A push and a pop on the same cycle leave the count unchanged.
module mtsp_mem_rqueue
    import mtsp_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int DEPTH  = RQ_DEPTH_D,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [CW-1:0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot the simultaneous push lands in
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mtsp_mem_responder.sv
// Burst memory responder for MTSP threads: write bursts with a done
// pulse, credit-limited read bursts through an in-order return queue.
module mtsp_mem_responder
    import mtsp_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int TID_W    = TID_W_D,
    parameter int LEN_W    = LEN_W_D,
    parameter int RQ_DEPTH = RQ_DEPTH_D
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic [TID_W-1:0]  CMD_TID,
    input  logic              WD_VALID,
    output logic              WD_READY,
    input  logic              WD_LAST,
    input  logic [DATA_W-1:0] WD_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic              RD_LAST,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [TID_W-1:0]  RD_TID,
    output logic              DONE_nEN,
    output logic [TID_W-1:0]  DONE_TID,
    output logic              M_REQ,
    input  logic              M_GNT,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic              M_RVALID,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic              BUSY,
    output logic              ERR
);

    localparam int CW = $clog2(RQ_DEPTH) + 1;

    mem_state_e        state;
    mem_state_e        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  idx_q;
    logic [TID_W-1:0]  tid_q;
    logic              err_q;
    logic [CW-1:0]     outst_q;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic [CW:0]       occ;

    logic in_wr;
    logic in_iss;
    logic cmd_fire;
    logic credit_ok;
    logic last_beat;
    logic wr_beat;
    logic rd_grant;
    logic rd_pop;
    logic ret_push;

    assign in_wr     = (state == ST_WR);
    assign in_iss    = (state == ST_RD_ISSUE);
    assign cmd_fire  = CMD_VALID && CMD_READY;
    assign last_beat = (rem_q == '0);
    // Outstanding grants plus queued beats may never exceed the queue
    assign occ       = {1'b0, outst_q} + {1'b0, q_count};
    assign credit_ok = occ < (CW + 1)'(RQ_DEPTH);
    assign wr_beat   = in_wr && WD_VALID && M_GNT;
    assign rd_grant  = in_iss && credit_ok && M_GNT;
    assign rd_pop    = RD_VALID && RD_READY;
    assign ret_push  = M_RVALID && (outst_q != '0);

    assign CMD_READY = nRST && (state == ST_IDLE);
    assign M_REQ     = (in_wr && WD_VALID) || (in_iss && credit_ok);
    assign M_WE      = in_wr;
    assign M_ADDR    = addr_q;
    assign M_WDATA   = in_wr ? WD_DATA : '0;
    assign WD_READY  = in_wr && M_GNT;
    assign RD_VALID  = !q_empty;
    assign RD_LAST   = RD_VALID && (idx_q == len_q);
    assign RD_TID    = tid_q;
    assign DONE_nEN  = (state != ST_WR_DONE);
    assign DONE_TID  = tid_q;
    assign BUSY      = (state != ST_IDLE) || !q_empty;
    assign ERR       = err_q;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_fire) state_d = CMD_WRITE ? ST_WR : ST_RD_ISSUE;
            end
            ST_WR: begin
                if (wr_beat && last_beat) state_d = ST_WR_DONE;
            end
            ST_WR_DONE:  state_d = ST_IDLE;
            ST_RD_ISSUE: begin
                if (rd_grant && last_beat) state_d = ST_RD_DRAIN;
            end
            ST_RD_DRAIN: begin
                if (rd_pop && RD_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            tid_q   <= '0;
            err_q   <= 1'b0;
            outst_q <= '0;
        end else begin
            state <= state_d;
            if (cmd_fire) begin
                addr_q <= CMD_ADDR;
                len_q  <= CMD_LEN;
                rem_q  <= CMD_LEN;
                tid_q  <= CMD_TID;
                idx_q  <= '0;
            end else begin
                if (wr_beat || rd_grant) begin
                    addr_q <= addr_q + ADDR_W'(BEAT_BYTES);
                    rem_q  <= rem_q - LEN_W'(1);
                end
                if (rd_pop) idx_q <= idx_q + LEN_W'(1);
            end
            // Length field decides termination; WD_LAST is only audited
            if (wr_beat && (WD_LAST != last_beat)) err_q <= 1'b1;
            unique case ({rd_grant, ret_push})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: ;
            endcase
        end
    end

    mtsp_mem_rqueue #(
        .DATA_W (DATA_W),
        .DEPTH  (RQ_DEPTH),
        .CW     (CW)
    ) u_rqueue (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (ret_push),
        .push_data (M_RDATA),
        .pop       (rd_pop),
        .pop_data  (RD_DATA),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_mtsp_mem_responder.sv
// Randomized bench for mtsp_mem_responder with a transaction-level
// memory model, burst scoreboard and directed corner cases.
module tb_mtsp_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int TW    = 3;
    localparam int LW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3000;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [LW-1:0] CMD_LEN = '0;
    logic [TW-1:0] CMD_TID = '0;
    logic          WD_VALID = 1'b0, WD_READY, WD_LAST = 1'b0;
    logic [DW-1:0] WD_DATA = '0;
    logic          RD_VALID, RD_READY = 1'b0, RD_LAST;
    logic [DW-1:0] RD_DATA;
    logic [TW-1:0] RD_TID, DONE_TID;
    logic          DONE_nEN;
    logic          M_REQ, M_GNT = 1'b0, M_WE;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WDATA;
    logic          M_RVALID = 1'b0;
    logic [DW-1:0] M_RDATA = '0;
    logic          BUSY, ERR;

    always #5 CLK = ~CLK;

    mtsp_mem_responder dut (
        .CLK(CLK), .nRST(nRST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR),
        .CMD_LEN(CMD_LEN), .CMD_TID(CMD_TID),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY),
        .WD_LAST(WD_LAST), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .RD_LAST(RD_LAST), .RD_DATA(RD_DATA), .RD_TID(RD_TID),
        .DONE_nEN(DONE_nEN), .DONE_TID(DONE_TID),
        .M_REQ(M_REQ), .M_GNT(M_GNT), .M_WE(M_WE),
        .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
        .M_RVALID(M_RVALID), .M_RDATA(M_RDATA),
        .BUSY(BUSY), .ERR(ERR)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        longint        rdy;
        logic [DW-1:0] d;
    } ret_t;

    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a, ~a, a ^ 32'h5A5A_C3C3, a + 32'h1234_5678};
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // Stimulus knobs
    int gnt_pct = 100, rdy_pct = 100, wdv_pct = 100;
    int lat_min = 1, lat_max = 1;

    // Pending command
    bit            cmd_pending = 0;
    bit            cmd_w;
    logic [AW-1:0] cmd_a;
    int            cmd_l;
    logic [TW-1:0] cmd_t;
    int            cmd_inj;

    // Transaction model
    bit            busy_m = 0, exp_done = 0, err_m = 0, is_wr = 0;
    logic [AW-1:0] c_addr;
    int            c_len;
    logic [TW-1:0] c_tid;
    int            inj_idx;
    int            wr_idx, iss_idx, popped;
    logic [DW-1:0] wbeats[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] model_rq[$];
    ret_t          pend[$];
    longint        cyc = 0, last_rdy = 0;

    function automatic logic [AW-1:0] beat_addr(input int i);
        return c_addr + AW'(16 * i);
    endfunction

    task automatic step();
        bit            rv, wr_ph, rd_ph, done_nx, err_nx;
        int            lat;
        longint        r;
        logic [AW-1:0] ea;
        ret_t          e;
        @(negedge CLK);
        cyc++;
        if (cyc > 95000) begin
            $display("FAIL watchdog: got=%0d exp<95000 cycles", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        CMD_VALID = cmd_pending;
        CMD_WRITE = cmd_w;
        CMD_ADDR  = cmd_a;
        CMD_LEN   = LW'(cmd_l);
        CMD_TID   = cmd_t;
        M_GNT     = pct(gnt_pct);
        RD_READY  = pct(rdy_pct);
        wr_ph = busy_m && is_wr && wr_idx <= c_len;
        rd_ph = busy_m && !is_wr && iss_idx <= c_len;
        if (wr_ph) begin
            WD_VALID = pct(wdv_pct);
            WD_DATA  = wbeats[wr_idx];
            WD_LAST  = (wr_idx == c_len) ^ (wr_idx == inj_idx);
        end else begin
            WD_VALID = pct(50);
            WD_DATA  = {$urandom, $urandom, $urandom, $urandom};
            WD_LAST  = $urandom_range(0, 1) == 1;
        end
        rv = pend.size() != 0 && pend[0].rdy <= cyc;
        M_RVALID = rv;
        M_RDATA  = rv ? pend[0].d : {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("cmd_ready", CMD_READY, !busy_m);
        check("busy", BUSY, busy_m);
        check("done_n", DONE_nEN, !exp_done);
        if (exp_done) check("done_tid", DONE_TID, c_tid);
        check("err", ERR, err_m);
        check("rd_valid", RD_VALID, model_rq.size() != 0);
        check("wd_ready", WD_READY, wr_ph && M_GNT);
        if (wr_ph) check("m_req_wr", M_REQ, WD_VALID);
        else if (rd_ph) check("m_req_rd", M_REQ, (iss_idx - popped) < DEPTH);
        else check("m_req_idle", M_REQ, 1'b0);

        done_nx = 0;
        err_nx  = 0;
        if (M_REQ && M_GNT && wr_ph) begin
            ea = beat_addr(wr_idx);
            check("wr_we", M_WE, 1'b1);
            check("wr_addr", M_ADDR, ea);
            check("wr_data", M_WDATA, wbeats[wr_idx]);
            mem[ea] = wbeats[wr_idx];
            if (WD_LAST != (wr_idx == c_len)) err_nx = 1;
            if (wr_idx == c_len) done_nx = 1;
            wr_idx++;
        end else if (M_REQ && M_GNT && rd_ph) begin
            check("rd_we", M_WE, 1'b0);
            check("rd_addr", M_ADDR, beat_addr(iss_idx));
            lat = int'($urandom_range(lat_max, lat_min));
            r = cyc + lat;
            if (r <= last_rdy) r = last_rdy + 1;
            last_rdy = r;
            e.rdy = r;
            e.d   = mem_rd(M_ADDR);
            pend.push_back(e);
            iss_idx++;
        end
        if (RD_VALID && RD_READY && model_rq.size() != 0) begin
            check("rd_data", RD_DATA, exp_rd[popped]);
            check("rd_tid", RD_TID, c_tid);
            check("rd_last", RD_LAST, popped == c_len);
            void'(model_rq.pop_front());
            popped++;
            if (popped == c_len + 1) busy_m = 0;
        end
        if (rv) begin
            model_rq.push_back(pend[0].d);
            void'(pend.pop_front());
        end
        if (exp_done) begin
            exp_done = 0;
            busy_m   = 0;
        end
        if (done_nx) exp_done = 1;
        if (err_nx) err_m = 1;
        if (CMD_VALID && CMD_READY) begin
            cmd_pending = 0;
            busy_m  = 1;
            is_wr   = cmd_w;
            c_addr  = cmd_a;
            c_len   = cmd_l;
            c_tid   = cmd_t;
            inj_idx = cmd_inj;
            wr_idx  = 0;
            iss_idx = 0;
            popped  = 0;
            wbeats.delete();
            exp_rd.delete();
            for (int i = 0; i <= cmd_l; i++) begin
                wbeats.push_back({$urandom, $urandom, $urandom, $urandom});
                exp_rd.push_back(mem_rd(beat_addr(i)));
            end
        end
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input int l,
                         input logic [TW-1:0] t, input int inj);
        cmd_w = w;
        cmd_a = a;
        cmd_l = l;
        cmd_t = t;
        cmd_inj = inj;
        cmd_pending = 1;
    endtask

    task automatic finish_cmd(input string tag);
        int n = 0;
        while ((cmd_pending || busy_m) && n < LIMIT) begin
            step();
            n++;
        end
        check(tag, n < LIMIT, 1'b1);
    endtask

    task automatic run_cmd(input bit w, input logic [AW-1:0] a, input int l,
                           input logic [TW-1:0] t, input int inj);
        issue(w, a, l, t, inj);
        finish_cmd("cmd_timeout");
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cmd_ready"}, CMD_READY, 1'b0);
        check({tag, "_m_req"}, M_REQ, 1'b0);
        check({tag, "_wd_ready"}, WD_READY, 1'b0);
        check({tag, "_rd_valid"}, RD_VALID, 1'b0);
        check({tag, "_done_n"}, DONE_nEN, 1'b1);
        check({tag, "_err"}, ERR, 1'b0);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_m_addr"}, M_ADDR, '0);
        check({tag, "_rd_tid"}, RD_TID, '0);
    endtask

    task automatic flush_model();
        busy_m = 0;
        exp_done = 0;
        err_m = 0;
        cmd_pending = 0;
        pend.delete();
        model_rq.delete();
        wbeats.delete();
        exp_rd.delete();
    endtask

    initial begin
        int n;
        #1;
        reset_checks("por");
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Unstalled 4-beat write, then done pulse
        run_cmd(1, 32'h100, 3, 3'd5, -1);

        // Queue fills after four grants with the reader stalled
        rdy_pct = 0;
        lat_min = 3;
        lat_max = 3;
        issue(0, 32'h0, 7, 3'd2, -1);
        repeat (20) step();
        check("grants_stall", iss_idx, 4);
        rdy_pct = 100;
        finish_cmd("drain_timeout");

        // Address wraps past the top of the space
        run_cmd(1, 32'hFFFF_FFF0, 1, 3'd1, -1);
        run_cmd(0, 32'hFFFF_FFF0, 1, 3'd6, -1);

        // Early WD_LAST: error flagged, all three beats still land
        run_cmd(1, 32'h200, 2, 3'd3, 0);
        check("err_sticky", ERR, 1'b1);
        run_cmd(0, 32'h200, 2, 3'd4, -1);

        // Reset in the middle of a read burst
        rdy_pct = 0;
        lat_min = 1;
        lat_max = 2;
        issue(0, 32'h40, 7, 3'd7, -1);
        n = 0;
        while (iss_idx < 3 && n < 100) begin
            step();
            n++;
        end
        check("pre_rst_grants", iss_idx >= 3, 1'b1);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        reset_checks("mid_rst");
        flush_model();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        rdy_pct = 100;
        run_cmd(0, 32'h40, 3, 3'd2, -1);

        // Randomized stall traffic
        for (int c = 0; c < 1000; c++) begin
            logic [AW-1:0] a;
            gnt_pct = int'($urandom_range(40, 100));
            rdy_pct = int'($urandom_range(40, 100));
            wdv_pct = int'($urandom_range(40, 100));
            lat_min = 1;
            lat_max = int'($urandom_range(1, 5));
            if (pct(5)) a = 32'hFFFF_FF00 + AW'(16 * $urandom_range(0, 15));
            else a = AW'({$urandom_range(0, 31), 4'h0});
            n = int'($urandom_range(0, 7));
            run_cmd($urandom_range(0, 1) == 1, a, n, TW'($urandom),
                    pct(10) ? int'($urandom_range(0, n)) : -1);
        end
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtsp_mem_responder.md
MTSP_MEM_RESPONDER -- requirements
Module: mtsp_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 128, beat width (one DWORDx4).
REQ-003 SHALL have parameter TID_W, default 3, thread-id width.
REQ-004 SHALL have parameter LEN_W, default 8, burst length field width; beats = CMD_LEN+1.
REQ-005 SHALL have parameter RQ_DEPTH, default 4, read-return queue depth (power of 2).
REQ-006 SHALL use one clock and an asynchronous active-low reset, with the following ports:
CLK  in  1  clock.
nRST  in  1  asynchronous active-low reset.
CMD_VALID  in  1  command valid.
CMD_READY  out  1  command accept.
CMD_WRITE  in  1  1=write, 0=read.
CMD_ADDR  in  ADDR_W  start byte address, 16-byte aligned.
CMD_LEN  in  LEN_W  beats-1.
CMD_TID  in  TID_W  issuing thread.
WD_VALID / WD_READY / WD_LAST  in/out/in  1 each  write data handshake.
WD_DATA  in  DATA_W  write beat.
RD_VALID / RD_READY / RD_LAST  out/in/out  1 each  read data handshake.
RD_DATA  out  DATA_W  read beat.
RD_TID  out  TID_W  owning thread.
DONE_nEN  out  1  write-complete pulse (active low).
DONE_TID  out  TID_W  thread to awaken.
M_REQ / M_GNT / M_WE  out/in/out  1 each  memory request, grant, write enable.
M_ADDR  out  ADDR_W  memory address.
M_WDATA  out  DATA_W  memory write data.
M_RVALID  in  1  read return, in order, latency >=1, no backpressure.
M_RDATA  in  DATA_W  read return data.
BUSY  out  1  state != IDLE or queue non-empty.
ERR  out  1  sticky WD_LAST mismatch flag.

Function
REQ-007 States IDLE, WR, WR_DONE, RD_ISSUE, RD_DRAIN; CMD_READY=1 only in IDLE.
REQ-008 IDLE: CMD_VALID&CMD_READY latches addr/len/tid/write; next WR or RD_ISSUE.
REQ-009 WR: M_REQ=WD_VALID, M_WE=1, M_WDATA=WD_DATA; WD_READY=M_GNT; beat retires when WD_VALID&M_GNT.
REQ-010 Each retired beat adds 16 to M_ADDR (mod 2^ADDR_W) and decrements the remaining count.
REQ-011 Final write beat -> WR_DONE; WR_DONE drives DONE_nEN=0 with DONE_TID for exactly one cycle, then IDLE.
REQ-012 WD_LAST on a non-final beat, or absent on the final beat, sets ERR; the beat count alone governs termination.
REQ-013 RD_ISSUE: M_REQ=1, M_WE=0 only when credit > 0. Credit = RQ_DEPTH - (outstanding + queued). Issue on M_GNT.
REQ-014 After the last read grant -> RD_DRAIN; RD_DRAIN -> IDLE on the cycle the final beat handshakes on RD.
REQ-015 M_RVALID pushes M_RDATA into the queue; RD_VALID = queue non-empty. RD_LAST marks beat index == len. RD_TID = latched tid.
REQ-016 Simultaneous push and pop on the same cycle SHALL keep occupancy unchanged, including at full and at empty.
REQ-017 Grant and return on the same cycle: credit unchanged.
REQ-018 Latency from command accept to first M_REQ SHALL be 1 cycle.
REQ-019 Inputs outside the active state are ignored: WD_* outside WR, M_GNT while M_REQ=0.

Reset
REQ-020 nRST low SHALL force the following immediately, mid-burst included: state IDLE, queue empty, credit RQ_DEPTH, CMD_READY=0 during reset, M_REQ=0, WD_READY=0, RD_VALID=0, DONE_nEN=1, ERR=0, BUSY=0, datapath registers 0.
REQ-021 The first cycle after reset release SHALL present CMD_READY=1.

Structure
REQ-022 State enum, beat stride (16) and default widths SHALL live in shared package mtsp_mem_pkg.
REQ-023 The read-return queue SHALL be sub-module mtsp_mem_rqueue (sync FIFO, count output).

Verification
REQ-024 Write addr 0x100, len 3, tid 5, M_GNT=1 -> M_ADDR 0x100, 0x110, 0x120, 0x130, then DONE_nEN low one cycle with DONE_TID=5.
REQ-025 Read addr 0x0, len 7, M latency 3, RD_READY=0 -> at most 4 grants; queue full; M_REQ low until RD_READY=1; 8 beats delivered in order; RD_LAST on beat 8.
REQ-026 Write addr 0xFFFFFFF0, len 1 -> second M_ADDR is 0x00000000.
REQ-027 Write len 2 with WD_LAST on beat 1 -> ERR=1; 3 beats are still written; DONE pulses.
REQ-028 nRST asserted mid read burst -> all outputs at reset values next edge; CMD_READY=1 after release; a new command completes normally.
REQ-029 Random M_GNT/M_RVALID/RD_READY stalls over 1000 commands -> scoreboard matches data, order and TID; no queue overflow.
